ad_cache_ctrl: RTL and testbench

AD_CACHE_CTRL -- requirements
Module: ad_cache_ctrl

---
 rtl/ad_cache_ctrl.sv | 140 ++++++++++++++
 tb/tb_ad_cache_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ad_cache_ctrl.sv
// Ping-pong capture controller: streams converter samples into a two-bank RAM and hands full banks to a reader.
// Latency: an accepted sample appears on wr/waddr/wdata one cycle later; rd_en/raddr/rd_last are combinational.
// Backpressure: when both banks are full the writer stalls and drops samples (sticky ovf); reads are gated by bank_rdy.
//
// Ports:
//   clk, rst (async, active-high), clr (sync clear)
//   en, ad_valid, ad_data            - capture side
//   wr, waddr, wdata                 - RAM port A (registered)
//   bank_rdy, rd, rd_en, raddr, rd_last - reader side / RAM port B
//   ovf                              - sticky sample-drop flag
module ad_cache_ctrl #(
    parameter int CHE_NBIT  = 10,
    parameter int DATA_NBIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 ad_valid,
    input  logic [DATA_NBIT-1:0] ad_data,
    output logic                 wr,
    output logic [CHE_NBIT:0]    waddr,
    output logic [DATA_NBIT-1:0] wdata,
    output logic                 bank_rdy,
    input  logic                 rd,
    output logic                 rd_en,
    output logic [CHE_NBIT:0]    raddr,
    output logic                 rd_last,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t              state;
    logic                wbank;
    logic                rbank;
    logic [CHE_NBIT-1:0] wcnt;
    logic [CHE_NBIT-1:0] rcnt;
    logic [1:0]          full;

    logic       accept;
    logic       drop;
    logic       wr_done;
    logic       rd_done;
    logic [1:0] wr_set;
    logic [1:0] rd_clr;
    logic [1:0] full_after_rd;

    // Reader side is purely combinational off the current bank state.
    assign bank_rdy = full[rbank];
    assign rd_en    = rd & full[rbank];
    assign raddr    = {rbank, rcnt};
    assign rd_last  = rd_en & (&rcnt);
    assign rd_done  = rd_last;

    assign accept  = (state == FILL) & en & ad_valid;
    assign drop    = (state == STALL) & en & ad_valid;
    assign wr_done = accept & (&wcnt);

    always_comb begin
        wr_set = 2'b00;
        rd_clr = 2'b00;
        if (wr_done) wr_set[wbank] = 1'b1;
        if (rd_done) rd_clr[rbank] = 1'b1;
    end

    // Writer decisions look at the flags as they will be after this edge's
    // reader clear, so a bank freed in the same cycle does not cause a stall.
    assign full_after_rd = full & ~rd_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= 2'b00;
            wr    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= 2'b00;
            wr    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ovf   <= 1'b0;
        end else begin
            wr <= accept;
            if (accept) begin
                waddr <= {wbank, wcnt};
                wdata <= ad_data;
                wcnt  <= wcnt + 1'b1;   // wraps to 0 on the last word
                if (wr_done) wbank <= ~wbank;
            end

            if (rd_en) begin
                rcnt <= rcnt + 1'b1;
                if (rd_done) rbank <= ~rbank;
            end

            // Set and clear never target the same bank.
            full <= full_after_rd | wr_set;

            if (drop) ovf <= 1'b1;

            case (state)
                IDLE: begin
                    // Resuming onto a bank the reader still owns would
                    // overwrite it, so wait in STALL instead.
                    if (en) state <= full_after_rd[wbank] ? STALL : FILL;
                end
                FILL: begin
                    if (!en)
                        state <= IDLE;
                    else if (wr_done && full_after_rd[~wbank])
                        state <= STALL;
                end
                STALL: begin
                    if (!en)
                        state <= IDLE;
                    else if (!full_after_rd[wbank])
                        state <= FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_cache_ctrl.sv
// Bench for ad_cache_ctrl with a 4-word bank: directed scenarios then random traffic.
// The reference tracks total words written/read as plain counters; bank occupancy,
// addresses and the stall condition are derived arithmetically from those totals.
module tb_ad_cache_ctrl;

    localparam int CN = 2;
    localparam int DW = 16;
    localparam int D  = 1 << CN;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic          ad_valid;
    logic [DW-1:0] ad_data;
    logic          wr;
    logic [CN:0]   waddr;
    logic [DW-1:0] wdata;
    logic          bank_rdy;
    logic          rd;
    logic          rd_en;
    logic [CN:0]   raddr;
    logic          rd_last;
    logic          ovf;

    ad_cache_ctrl #(.CHE_NBIT(CN), .DATA_NBIT(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .ad_valid(ad_valid), .ad_data(ad_data),
        .wr(wr), .waddr(waddr), .wdata(wdata),
        .bank_rdy(bank_rdy), .rd(rd), .rd_en(rd_en),
        .raddr(raddr), .rd_last(rd_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: absolute word totals plus writer activity flags.
    int wtot, rtot;
    bit live;      // writer left IDLE (en seen at the previous edge)
    bit blocked;   // both banks held by the reader at the previous edge
    bit m_wr, m_ovf;
    int m_waddr, m_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wtot = 0; rtot = 0; live = 0; blocked = 0;
        m_wr = 0; m_ovf = 0; m_waddr = 0; m_wdata = 0;
    endtask

    function automatic bit m_ready();
        return (wtot / D) > (rtot / D);
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".wr"},    wr,    m_wr);
        chk({tag, ".waddr"}, waddr, m_waddr);
        chk({tag, ".wdata"}, wdata, m_wdata);
        chk({tag, ".ovf"},   ovf,   m_ovf);
    endtask

    task automatic check_comb(input string tag);
        bit ren;
        ren = rd && m_ready();
        chk({tag, ".bank_rdy"}, bank_rdy, m_ready());
        chk({tag, ".rd_en"},    rd_en,    ren);
        chk({tag, ".raddr"},    raddr,    rtot % (2 * D));
        chk({tag, ".rd_last"},  rd_last,  ren && (rtot % D == D - 1));
    endtask

    // One clock: drive at negedge, check combinational outputs, then
    // advance the reference at the edge and check registered outputs.
    task automatic step(input string tag, input bit e, input bit v,
                        input logic [DW-1:0] d, input bit r, input bit c);
        bit ready, acc, drp;
        @(negedge clk);
        en = e; ad_valid = v; ad_data = d; rd = r; clr = c;
        #1;
        check_comb(tag);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            ready = m_ready();
            acc   = live && e && v && !blocked;
            drp   = live && e && v && blocked;
            m_wr  = acc;
            if (acc) begin
                m_waddr = wtot % (2 * D);
                m_wdata = d;
                wtot++;
            end
            if (r && ready) rtot++;
            if (drp) m_ovf = 1;
            blocked = (wtot - (rtot / D) * D) == 2 * D;
            live = e;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic async_reset(input string tag);
        en = 0; ad_valid = 0; rd = 0; clr = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        check_comb(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 0; clr = 0; ad_valid = 0; ad_data = '0; rd = 0;
        model_reset();
        #12;
        check_regs("reset");
        check_comb("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic fill: data 1..4 into bank 0.
        step("fill_en", 1, 0, 0, 0, 0);
        for (int i = 1; i <= D; i++) step("fill", 1, 1, DW'(i), 0, 0);
        step("fill_done", 1, 0, 0, 0, 0);

        // Bank read, then one extra rd with nothing ready.
        for (int i = 0; i < D; i++) step("read", 1, 0, 0, 1, 0);
        step("read_empty", 1, 0, 0, 1, 0);

        // Overflow: 8 samples fill both banks, 9th is dropped.
        step("clr", 0, 0, 0, 0, 1);
        step("ovf_en", 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * D + 1; i++) step("ovf_fill", 1, 1, DW'(16'h100 + i), 0, 0);
        // Drain bank 0 while samples keep arriving (last pop cycle still drops).
        for (int i = 0; i < D; i++) step("ovf_drain", 1, 1, DW'(16'h200 + i), 1, 0);
        step("ovf_resume", 1, 1, 16'h0300, 0, 0);

        // Simultaneous: bank 0 completes as the reader pops bank 1's last word.
        step("sim_w", 1, 1, 16'h0301, 0, 0);
        step("sim_w", 1, 1, 16'h0302, 1, 0);
        step("sim_r", 1, 0, 0, 1, 0);
        step("sim_r", 1, 0, 0, 1, 0);
        step("sim_both", 1, 1, 16'h0303, 1, 0);
        step("sim_next", 1, 1, 16'h0304, 0, 0);

        // Enable gap.
        step("clr", 0, 0, 0, 0, 1);
        step("gap_en", 1, 0, 0, 0, 0);
        step("gap_w", 1, 1, 16'h0a0, 0, 0);
        step("gap_w", 1, 1, 16'h0a1, 0, 0);
        step("gap_off", 0, 1, 16'h0a2, 0, 0);
        step("gap_off", 0, 1, 16'h0a3, 0, 0);
        step("gap_on", 1, 1, 16'h0a4, 0, 0);
        step("gap_w", 1, 1, 16'h0a5, 0, 0);
        step("gap_w", 1, 1, 16'h0a6, 0, 0);
        step("gap_idle", 1, 0, 0, 0, 0);

        // Reset while waddr 5 is being written with bank 0 full.
        step("clr", 0, 0, 0, 0, 1);
        step("rst_en", 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("rst_w", 1, 1, DW'(16'h0b0 + i), 0, 0);
        chk("rst_pre.waddr", waddr, 5);
        async_reset("rst_mid");
        step("rst_en", 1, 0, 0, 0, 0);
        step("rst_after", 1, 1, 16'h0c0, 0, 0);
        chk("rst_after.waddr", waddr, 0);

        // Random traffic with occasional clears and resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
            step("rnd",
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 DW'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 249) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
